// File: rtl/debug_state_serial_tx_pkg.sv
// Shared types and helpers for the debug-state serial transmitter.
package debug_state_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    GAP
  } state_e;

  localparam int FRAME_BITS = 33;

  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/debug_tx_bit_timer.sv
// Half-period counter producing one-cycle oSClk rise/fall ticks.
module debug_tx_bit_timer #(
  parameter int HALF_PER = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iRestart,
  output logic oFall,
  output logic oRise
);

  localparam int PER = 2 * HALF_PER;
  localparam int CW  = $clog2(PER);
  localparam logic [CW-1:0] RISE_AT = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] LAST    = CW'(PER - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (iRestart)
      cnt_d = '0;
    else if (iEn)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign oRise = iEn && !iRestart && (cnt_q == RISE_AT);
  assign oFall = iEn && !iRestart && (cnt_q == LAST);

endmodule

// File: rtl/debug_state_serial_tx.sv
// Snapshots current/previous debug state and shifts it out with even
// parity over a clock/data/load link.
module debug_state_serial_tx
  import debug_state_serial_tx_pkg::*;
#(
  parameter int HALF_PER    = 4,
  parameter int GAP_BITS    = 8,
  parameter int CLR_ON_SEND = 0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [15:0] iCurrState,
  input  logic [15:0] iPrevState,
  input  logic        iSendReq,
  input  logic        iAutoEn,
  output logic        oSClk,
  output logic        oSData,
  output logic        oSLoad,
  output logic        oBusy,
  output logic        oClear
);

  localparam int GTOT = GAP_BITS * 2 * HALF_PER;
  localparam int GW   = (GTOT > 0) ? $clog2(GTOT + 1) : 1;
  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GTOT - 1);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [5:0]              bit_q, bit_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [15:0]             last_q, last_d;
  logic                    sclk_q, sclk_d;
  logic                    pend_q, pend_d;
  logic                    clr_q, clr_d;
  logic                    trig;
  logic                    tm_en, tm_fall, tm_rise;

  assign tm_en = (state_q == SHIFT) || (state_q == LATCH);

  debug_tx_bit_timer #(
    .HALF_PER(HALF_PER)
  ) u_timer (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (tm_en),
    .iRestart(trig),
    .oFall   (tm_fall),
    .oRise   (tm_rise)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      sclk_q  <= 1'b0;
      pend_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      pend_q  <= pend_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    pend_d  = pend_q;
    clr_d   = 1'b0;
    trig    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q || iSendReq ||
            (iAutoEn && (iCurrState != last_q))) begin
          trig    = 1'b1;
          state_d = SHIFT;
          sh_d    = {iCurrState, iPrevState,
                     even_par({iCurrState, iPrevState})};
          last_d  = iCurrState;
          pend_d  = 1'b0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          clr_d   = (CLR_ON_SEND != 0);
        end
      end
      SHIFT: begin
        if (tm_rise) sclk_d = 1'b1;
        if (tm_fall) begin
          sclk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q + 6'd1;
            sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        if (tm_fall) begin
          if (GTOT == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Requests during a frame merge into a single pending slot.
    if ((state_q != IDLE) && iSendReq) pend_d = 1'b1;
  end

  assign oSClk  = sclk_q;
  assign oSData = (state_q == SHIFT) ? sh_q[FRAME_BITS-1] : 1'b0;
  assign oSLoad = (state_q == LATCH);
  assign oBusy  = (state_q != IDLE);
  assign oClear = clr_q;

endmodule

// File: tb/tb_debug_state_serial_tx.sv
// Directed bench for debug_state_serial_tx (default and fast/clear configs).
module tb_debug_state_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cur = '0;
  logic [15:0] prev = '0;
  logic        req1 = 1'b0;
  logic        req2 = 1'b0;
  logic        auto1 = 1'b0;
  logic        auto2 = 1'b0;
  logic        sel = 1'b0;

  logic sclk1, sdata1, load1, busy1, clr1;
  logic sclk2, sdata2, load2, busy2, clr2;
  logic m_sclk, m_sdata, m_load, m_busy, m_clr;

  int checks = 0;
  int errors = 0;
  int nbi;

  always #5 clk = ~clk;

  debug_state_serial_tx u_dut1 (
    .iClk      (clk),
    .iRst      (rst),
    .iCurrState(cur),
    .iPrevState(prev),
    .iSendReq  (req1),
    .iAutoEn   (auto1),
    .oSClk     (sclk1),
    .oSData    (sdata1),
    .oSLoad    (load1),
    .oBusy     (busy1),
    .oClear    (clr1)
  );

  debug_state_serial_tx #(
    .HALF_PER   (1),
    .GAP_BITS   (0),
    .CLR_ON_SEND(1)
  ) u_dut2 (
    .iClk      (clk),
    .iRst      (rst),
    .iCurrState(cur),
    .iPrevState(prev),
    .iSendReq  (req2),
    .iAutoEn   (auto2),
    .oSClk     (sclk2),
    .oSData    (sdata2),
    .oSLoad    (load2),
    .oBusy     (busy2),
    .oClear    (clr2)
  );

  assign m_sclk  = sel ? sclk2  : sclk1;
  assign m_sdata = sel ? sdata2 : sdata1;
  assign m_load  = sel ? load2  : load1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_clr   = sel ? clr2   : clr1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the first negedge after the trigger edge.
  task automatic run_frame(input logic [32:0] exp_f, input int exp_busy,
                           input int exp_load, input int exp_clr,
                           input int exp_clr_first);
    logic [32:0] f = '0;
    logic        p = 1'b0;
    int nb = 0, nl = 0, nbusy = 0, nclr = 0, cfirst = -1;
    int i = 0;
    while (m_busy && i < 3000) begin
      nbusy++;
      if (m_sclk && !p) begin
        f = {f[31:0], m_sdata};
        nb++;
      end
      if (m_load) nl++;
      if (m_clr) begin
        if (cfirst < 0) cfirst = nbusy;
        nclr++;
      end
      p = m_sclk;
      @(negedge clk);
      i++;
    end
    chk("frame_end", 64'(m_busy), 64'(0));
    chk("frame_bits", 64'(f), 64'(exp_f));
    chk("frame_nbits", 64'(nb), 64'(33));
    chk("frame_busy_cycles", 64'(nbusy), 64'(exp_busy));
    chk("frame_load_cycles", 64'(nl), 64'(exp_load));
    chk("frame_clr_cycles", 64'(nclr), 64'(exp_clr));
    chk("frame_clr_first", 64'(cfirst), 64'(exp_clr_first));
  endtask

  task automatic idle_count(input int n, output int nb);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_busy) nb++;
    end
  endtask

  task automatic latency(input logic b);
    chk("lat_busy", 64'(m_busy), 64'(1));
    chk("lat_sdata", 64'(m_sdata), 64'(b));
    chk("lat_sclk", 64'(m_sclk), 64'(0));
  endtask

  task automatic pulse_req1;
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out1", 64'({sclk1, sdata1, load1, busy1, clr1}), 64'(0));
    chk("rst_out2", 64'({sclk2, sdata2, load2, busy2, clr2}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 64'(busy1), 64'(0));

    cur = 16'hA55A; prev = 16'h0F0F;
    pulse_req1();
    latency(1'b1);
    run_frame({16'hA55A, 16'h0F0F, 1'b0}, 336, 8, 0, -1);

    cur = 16'h0001; prev = 16'h0000;
    pulse_req1();
    latency(1'b0);
    run_frame({16'h0001, 16'h0000, 1'b1}, 336, 8, 0, -1);

    cur = 16'h0003; prev = 16'h0001;
    pulse_req1();
    run_frame({16'h0003, 16'h0001, 1'b1}, 336, 8, 0, -1);

    cur = 16'h0000; prev = 16'h0000; auto1 = 1'b1;
    @(negedge clk);
    chk("auto_start", 64'(busy1), 64'(1));
    fork
      run_frame({16'h0000, 16'h0000, 1'b0}, 336, 8, 0, -1);
      begin
        repeat (100) @(negedge clk);
        cur = 16'h0001;
        repeat (100) @(negedge clk);
        cur = 16'h0002;
      end
    join
    @(negedge clk);
    chk("auto_followup", 64'(busy1), 64'(1));
    run_frame({16'h0002, 16'h0000, 1'b1}, 336, 8, 0, -1);
    idle_count(400, nbi);
    chk("auto_hold_idle", 64'(nbi), 64'(0));
    auto1 = 1'b0;

    cur = 16'h1234; prev = 16'h5678;
    pulse_req1();
    fork
      run_frame({16'h1234, 16'h5678, 1'b1}, 336, 8, 0, -1);
      begin
        repeat (3) begin
          repeat (60) @(negedge clk);
          req1 = 1'b1;
          @(negedge clk);
          req1 = 1'b0;
        end
      end
    join
    @(negedge clk);
    chk("pend_start", 64'(busy1), 64'(1));
    run_frame({16'h1234, 16'h5678, 1'b1}, 336, 8, 0, -1);
    idle_count(400, nbi);
    chk("pend_single", 64'(nbi), 64'(0));

    sel = 1'b1;
    cur = 16'hBEEF; prev = 16'hCAFE;
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    latency(1'b1);
    chk("clr_first_cycle", 64'(clr2), 64'(1));
    fork
      run_frame({16'hBEEF, 16'hCAFE, 1'b0}, 68, 2, 1, 1);
      begin
        #1;
        cur = 16'h0000;
        prev = 16'h0000;
      end
    join
    chk("clr_low_after", 64'(clr2), 64'(0));
    sel = 1'b0;

    cur = 16'h00F0; prev = 16'h0000;
    pulse_req1();
    repeat (76) @(negedge clk);
    chk("mid_frame_busy", 64'(busy1), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_async", 64'({sclk1, sdata1, load1, busy1, clr1}), 64'(0));
    @(negedge clk);
    chk("abort_hold", 64'({sclk1, sdata1, load1, busy1, clr1}), 64'(0));
    rst = 1'b0;
    idle_count(400, nbi);
    chk("post_rst_idle", 64'(nbi), 64'(0));
    auto1 = 1'b1;
    @(negedge clk);
    latency(1'b0);
    run_frame({16'h00F0, 16'h0000, 1'b0}, 336, 8, 0, -1);
    auto1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_state_serial_tx.md
# debug_state_serial_tx

Serial transmitter for the 16-bit debug-state history (current state plus previous state) held by the state logger. It snapshots both words, appends even parity, and shifts the frame out MSB-first on a clock/data/load three-wire link to the BMC or a debug header. An optional one-cycle clear request re-arms the logger after each snapshot.

## Interface
- HALF_PER, 4, iClk cycles per oSClk half-period; legal range 1..255
- GAP_BITS, 8, idle bit-periods inserted after each frame before the next trigger is accepted; legal range 0..255
- CLR_ON_SEND, 0, 1 = pulse oClear after each snapshot
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iCurrState  in  16  logged current debug state
- iPrevState  in  16  logged previous debug state
- iSendReq  in  1  single-cycle request to transmit one frame
- iAutoEn  in  1  1 = transmit automatically whenever iCurrState differs from the last transmitted current state
- oSClk  out  1  serial clock; idle low
- oSData  out  1  serial data; changes only on oSClk falling edges or while oSClk is low
- oSLoad  out  1  frame-latch strobe for the receiver
- oBusy  out  1  frame in progress, including the gap
- oClear  out  1  one-cycle clear request to the logger

## Operation
- States: IDLE, SHIFT, LATCH, GAP.
- Reset value of all outputs is 0. Internal state after reset: last-sent register 0, pending flag 0, FSM in IDLE.
- Trigger in IDLE: the pending flag is set, or iSendReq=1, or (iAutoEn=1 and iCurrState != last-sent).
- On the trigger edge:
  - Load the 33-bit shift register with {iCurrState, iPrevState, P}, where P = XOR of all 32 bits, so the frame has even total parity.
  - Set last-sent to iCurrState and clear the pending flag.
  - Go to SHIFT.
- SHIFT:
  - Sends 33 bits, MSB first (iCurrState[15] first, P last).
  - Each bit period is HALF_PER cycles with oSClk=0, then HALF_PER cycles with oSClk=1. The receiver samples on the rising edge.
  - The next bit is driven on the same edge that takes oSClk low.
  - After bit 33's high phase, go to LATCH.
- LATCH: oSClk=0, oSData=0, oSLoad=1 for 2*HALF_PER cycles, then go to GAP.
- GAP: all link outputs low for GAP_BITS*2*HALF_PER cycles, then go to IDLE. If GAP_BITS=0, LATCH goes straight to IDLE.
- oBusy=1 in every state except IDLE.
- An iSendReq that arrives while oBusy=1 sets the pending flag. The flag is one deep, so further requests merge into it.
- Auto-change detection is evaluated only in IDLE. State changes during a frame are picked up by comparing against last-sent on return to IDLE. Intermediate values are not queued.
- oClear (only when CLR_ON_SEND=1): high for exactly the one cycle after the trigger edge. The snapshot has already been taken, so the clear cannot corrupt it.
- Asserting iRst mid-frame aborts the frame immediately and asynchronously. All outputs go to 0 and the pending flag and last-sent register are cleared.

## Timing
- Trigger latency: oBusy=1 and oSData = iCurrState[15] are visible from the trigger edge, i.e. one cycle after iSendReq is sampled high.
- Frame duration, measured from the trigger edge back to IDLE: (33 + 1 + GAP_BITS) * 2 * HALF_PER cycles. With the defaults this is 336 cycles.
- oSLoad rises on the edge after the last oSClk high phase ends.
- A back-to-back pending frame starts on the first IDLE cycle, one cycle after GAP ends.
- Counter widths:
  - Phase counter: ceil(log2(HALF_PER*2)) bits.
  - Bit counter: 6 bits.
  - Gap counter: ceil(log2(GAP_BITS*2*HALF_PER + 1)) bits.
- No counter wraps within a frame.

## Structure
- Shared package holds:
  - the state enum {IDLE, SHIFT, LATCH, GAP};
  - the localparam FRAME_BITS = 33;
  - the even-parity function over 32 bits.
- Sub-module `debug_tx_bit_timer` implements the half-period counter. It is parameterised by HALF_PER, takes an enable and a synchronous restart, and outputs a one-cycle fall tick and a one-cycle rise tick. The top level contains the FSM, shift register, bit and gap counters, and the pending/last-sent logic.

## Test plan
- Reset, then pulse iSendReq with iCurrState=16'hA55A, iPrevState=16'h0F0F (defaults) -> 33 rising-edge samples read A55A, 0F0F, P=0; oSLoad high 8 cycles; oBusy low exactly 336 cycles after the trigger edge.
- iCurrState=16'h0001, iPrevState=0 -> P=1. Flip iCurrState to 16'h0003 -> P=1 (three ones, even total).
- iAutoEn=1, iCurrState steps 0→1→2 mid-frame -> exactly one follow-up frame, carrying 2. Holding 2 produces no further frames.
- Three iSendReq pulses during a busy frame -> exactly one extra frame, starting one cycle after GAP ends.
- CLR_ON_SEND=1 -> oClear high for exactly one cycle, the cycle after the trigger edge; the frame still carries the pre-clear values.
- Assert iRst for 1 cycle at bit 10 -> all outputs 0 while reset is high. After release, with no request and iAutoEn=0, the block stays idle; iAutoEn=1 with iCurrState≠0 sends a fresh full frame.
